// File: rtl/key_event_filter.sv
// key_event_filter: synchronise, debounce and encode 16 raw keypad levels into levels, press pulses and a key event.
// Define KEY_EVENT_FILTER_AUTO_REPEAT_EN to add auto-repeat pulses on the REPEAT_MASK keys.
module key_event_filter #(
    parameter int          TICK_DIV     = 100000,
    parameter int          STABLE_TICKS = 10,
    parameter logic [15:0] REPEAT_MASK  = 16'h00E4,
    parameter int          REPEAT_DELAY = 400,
    parameter int          REPEAT_RATE  = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] btn_raw,
    output logic [15:0] btn_level,
    output logic [15:0] btn_press,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        multi_press
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);
`ifdef KEY_EVENT_FILTER_AUTO_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
`endif

    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [15:0]   w_flip;
    logic [15:0]   w_press;
    logic [3:0]    w_code;

    assign w_tick = r_tick_cnt == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        end
    end

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_key
            logic [SW-1:0] r_stab;
            logic          w_diff;
            assign w_diff    = r_sync2[k] ^ btn_level[k];
            assign w_flip[k] = w_tick && w_diff && r_stab == SW'(STABLE_TICKS - 1);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_stab <= '0;
                else if (w_tick)
                    r_stab <= (w_diff && !w_flip[k]) ? r_stab + SW'(1) : '0;
            end
`ifdef KEY_EVENT_FILTER_AUTO_REPEAT_EN
            if (REPEAT_MASK[k]) begin : g_rep
                logic [RW-1:0] r_rep;
                logic          r_rate;
                logic          w_hit;
                // First target is the hold delay, every later one the repeat rate
                assign w_hit = w_tick && btn_level[k] && !w_flip[k] &&
                               (r_rep + RW'(1)) == (r_rate ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_rep  <= '0;
                        r_rate <= 1'b0;
                    end else if (!btn_level[k]) begin
                        r_rep  <= '0;
                        r_rate <= 1'b0;
                    end else if (w_hit) begin
                        r_rep  <= '0;
                        r_rate <= 1'b1;
                    end else if (w_tick) begin
                        r_rep  <= r_rep + RW'(1);
                    end
                end
                assign w_press[k] = (w_flip[k] && !btn_level[k]) || w_hit;
            end else begin : g_norep
                assign w_press[k] = w_flip[k] && !btn_level[k];
            end
`else
            assign w_press[k] = w_flip[k] && !btn_level[k];
`endif
        end
    endgenerate

    always_comb begin
        w_code = '0;
        for (int i = 15; i >= 0; i--)
            if (w_press[i]) w_code = 4'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level   <= '0;
            btn_press   <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            multi_press <= 1'b0;
        end else begin
            btn_level   <= btn_level ^ w_flip;
            btn_press   <= w_press;
            key_valid   <= |w_press;
            key_code    <= w_code;
            multi_press <= (w_press & (w_press - 16'd1)) != '0;
        end
    end
endmodule

// File: tb/tb_key_event_filter.sv
// tb_key_event_filter: vector table, corner sequences and random stimulus against a tick-level reference model.
module tb_key_event_filter;
    localparam int          TD   = 4;
    localparam int          ST   = 3;
    localparam int          RD   = 5;
    localparam int          RR   = 2;
    localparam logic [15:0] MASK = 16'h00E4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] btn_raw = '0;
    logic [15:0] btn_level;
    logic [15:0] btn_press;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        multi_press;

    always #5 clk = ~clk;

    key_event_filter #(
        .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_MASK(MASK), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
        .key_valid(key_valid), .key_code(key_code), .multi_press(multi_press)
    );

    int vectors = 0;
    int miscompares = 0;

    int          m_cyc;
    logic [15:0] m_d1, m_d2, m_level, m_press;
    int          m_diff [16];
    int          m_held [16];

    int          n_valid, first_v;
    logic [3:0]  v_code;
    logic        v_multi;
    logic [15:0] lvl_seen;

    typedef struct {
        logic [15:0] raw;
        logic [15:0] level;
        int          presses;
        logic [3:0]  code;
        logic        multi;
    } vec_t;
    vec_t tbl [6];

    function automatic void model_reset();
        m_cyc = 0; m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0;
        for (int k = 0; k < 16; k++) begin
            m_diff[k] = 0;
            m_held[k] = 0;
        end
    endfunction

    // Behaviour in ticks: a level flips after ST consecutive disagreeing samples
    function automatic void model_step();
        logic [15:0] was;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was = m_level;
        m_press = '0;
        if (m_cyc % TD == TD - 1)
            for (int k = 0; k < 16; k++) begin
                if (m_d2[k] == m_level[k])
                    m_diff[k] = 0;
                else begin
                    m_diff[k]++;
                    if (m_diff[k] == ST) begin
                        m_diff[k] = 0;
                        m_level[k] = ~m_level[k];
                        m_press[k] = m_level[k];
                    end
                end
`ifdef KEY_EVENT_FILTER_AUTO_REPEAT_EN
                if (MASK[k] && was[k] && m_level[k]) begin
                    m_held[k]++;
                    if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RR == 0))
                        m_press[k] = 1'b1;
                end
`endif
            end
        for (int k = 0; k < 16; k++)
            if (!m_level[k]) m_held[k] = 0;
        m_d2 = m_d1;
        m_d1 = btn_raw;
        m_cyc++;
    endfunction

    function automatic void compare();
        int   code;
        logic ev, mul;
        code = 0;
        for (int i = 15; i >= 0; i--)
            if (m_press[i]) code = i;
        ev  = |m_press;
        mul = $countones(m_press) > 1;
        vectors++;
        if (btn_level !== m_level || btn_press !== m_press || key_valid !== ev ||
            key_code !== 4'(code) || multi_press !== mul) begin
            miscompares++;
            $display("FAIL model t=%0t: level %h want %h, press %h want %h, valid %b want %b, code %0d want %0d, multi %b want %b",
                     $time, btn_level, m_level, btn_press, m_press, key_valid, ev, key_code, code, multi_press, mul);
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_stats();
        n_valid = 0; first_v = -1; v_code = '0; v_multi = 1'b0; lvl_seen = '0;
    endtask

    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (key_valid) begin
                if (n_valid == 0) begin
                    first_v = i;
                    v_code  = key_code;
                    v_multi = multi_press;
                end
                n_valid++;
            end
            lvl_seen |= btn_level;
        end
    endtask

    task automatic reset_dut();
        btn_raw = '0;
        rst_n = 1'b0;
        model_reset();
        run(2);
        rst_n = 1'b1;
    endtask

    int p [$];
    int fall;
    int late;

    initial begin
        tbl[0] = '{16'h0400, 16'h0400, 1, 4'd10, 1'b0};
        tbl[1] = '{16'h1020, 16'h1020, 1, 4'd5,  1'b1};
        tbl[2] = '{16'h0001, 16'h0001, 1, 4'd0,  1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1, 4'd15, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 0, 4'd0,  1'b0};
        tbl[5] = '{16'hA5A5, 16'hA5A5, 1, 4'd0,  1'b1};

        model_reset();
        @(negedge clk);

        // Reset asserted mid-count with every key held, then released
        reset_dut();
        btn_raw = 16'hFFFF;
        run(30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst level", int'(btn_level), 0);
        chk("rst press", int'(btn_press), 0);
        chk("rst valid", int'(key_valid), 0);
        chk("rst code", int'(key_code), 0);
        chk("rst multi", int'(multi_press), 0);
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        clear_stats();
        run(20);
        chk("rst rel level", int'(btn_level), 16'hFFFF);
        chk("rst rel bursts", n_valid, 1);
        chk("rst rel code", int'(v_code), 0);
        chk("rst rel multi", int'(v_multi), 1);
        chk_rng("rst rel latency", first_v, 11, 15);

        foreach (tbl[i]) begin
            reset_dut();
            run(4);
            btn_raw = tbl[i].raw;
            clear_stats();
            run(20);
            chk($sformatf("vec%0d level", i), int'(btn_level), int'(tbl[i].level));
            chk($sformatf("vec%0d presses", i), n_valid, tbl[i].presses);
            chk($sformatf("vec%0d code", i), int'(v_code), int'(tbl[i].code));
            chk($sformatf("vec%0d multi", i), int'(v_multi), int'(tbl[i].multi));
            if (tbl[i].presses > 0)
                chk_rng($sformatf("vec%0d latency", i), first_v, 11, 15);
        end

        // Glitch of 8 clk on key 2
        reset_dut();
        run(4);
        btn_raw = 16'h0004;
        clear_stats();
        run(8);
        btn_raw = '0;
        run(30);
        chk("glitch level", int'(lvl_seen[2]), 0);
        chk("glitch presses", n_valid, 0);

        // Release of key 14 gives no pulse
        reset_dut();
        btn_raw = 16'h4000;
        run(20);
        chk("release held", int'(btn_level), 16'h4000);
        btn_raw = '0;
        clear_stats();
        fall = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (key_valid) n_valid++;
            if (fall < 0 && !btn_level[14]) fall = i;
        end
        chk_rng("release latency", fall, 11, 15);
        chk("release pulses", n_valid, 0);

`ifdef KEY_EVENT_FILTER_AUTO_REPEAT_EN
        reset_dut();
        run(4);
        btn_raw = 16'h0040;
        p.delete();
        for (int i = 1; i <= 60; i++) begin
            cyc();
            if (btn_press[6]) p.push_back(i);
        end
        chk("rep count", p.size() >= 4 ? 1 : 0, 1);
        if (p.size() >= 4) begin
            chk("rep delay", p[1] - p[0], 20);
            chk("rep rate1", p[2] - p[1], 8);
            chk("rep rate2", p[3] - p[2], 8);
        end
        btn_raw = '0;
        late = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (!btn_level[6] && btn_press[6]) late++;
        end
        chk("rep stop", late, 0);
        reset_dut();
        btn_raw = 16'h0400;
        clear_stats();
        run(60);
        chk("rep unmasked", n_valid, 1);
`endif

        // Random key activity with occasional asynchronous resets
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) btn_raw[$urandom_range(15)] ^= 1'b1;
            if ($urandom_range(15) == 0) btn_raw = btn_raw ^ 16'($urandom_range(65535) & $urandom_range(65535));
            if ($urandom_range(999) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                run(2);
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
